// File: rtl/sum_sequencer.sv
// Memory-side sequencer: reads COUNT words starting at base_addr, accumulates them,
// and writes the 16-bit sum to dest_addr. All outputs are registered from next-state.
module sum_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] count,
  input  logic [ADDR_W-1:0] dest_addr,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] sum,
  output logic              overflow,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_ACC  = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W:0]   add_s;
  logic [ADDR_W:0]   next_index_s;

  // Next-state, datapath update, and next-cycle output decode
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    count_d      = count_q;
    dest_d       = dest_q;
    index_d      = index_q;
    sum_d        = sum_q;
    ovf_d        = ovf_q;
    add_s        = {1'b0, sum_q} + {1'b0, mem_rdata};
    next_index_s = {1'b0, index_q} + {{ADDR_W{1'b0}}, 1'b1};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          count_d = count;
          dest_d  = dest_addr;
          index_d = '0;
          sum_d   = '0;
          ovf_d   = 1'b0;
          if (count != '0) begin
            state_d = S_RD;
          end else begin
            state_d = S_WR;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD:   state_d = S_ACC;
      S_ACC: begin
        sum_d   = add_s[DATA_W-1:0];
        ovf_d   = ovf_q | add_s[DATA_W];
        index_d = next_index_s[ADDR_W-1:0];
        if (next_index_s < {1'b0, count_q}) begin
          state_d = S_RD;
        end else begin
          state_d = S_WR;
        end
      end
      S_WR:   state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the state being entered so they register cleanly
    busy_d  = (state_d == S_RD) || (state_d == S_ACC) || (state_d == S_WR);
    done_d  = (state_d == S_DONE);
    rd_d    = (state_d == S_RD);
    wr_d    = (state_d == S_WR);
    case (state_d)
      S_RD: begin
        addr_d  = base_d + index_d;
        wdata_d = '0;
      end
      S_WR: begin
        addr_d  = dest_d;
        wdata_d = sum_d;
      end
      default: begin
        addr_d  = '0;
        wdata_d = '0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      count_q <= '0;
      dest_q  <= '0;
      index_q <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      count_q <= count_d;
      dest_q  <= dest_d;
      index_q <= index_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign sum         = sum_q;
  assign overflow    = ovf_q;
  assign mem_read    = rd_q;
  assign mem_write   = wr_q;
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;

endmodule

// File: tb/tb_sum_sequencer.sv
// Directed bench for sum_sequencer with a behavioural 256x16 registered-read memory.
module tb_sum_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  base_addr, count, dest_addr;
  logic        busy, done, overflow, mem_read, mem_write;
  logic [15:0] sum, mem_wdata, mem_rdata;
  logic [7:0]  mem_address;

  logic [15:0] mem [0:255];
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [15:0] pl_data;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  sum_sequencer dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .base_addr(base_addr), .count(count), .dest_addr(dest_addr),
    .busy(busy), .done(done), .sum(sum), .overflow(overflow),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory model: registered read, write on posedge, bench preload port
  always @(posedge clock) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_write) mem[mem_address] <= mem_wdata;
    if (mem_read) mem_rdata <= mem[mem_address];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clock);
    pl_en = 1'b0;
  endtask

  // One run from IDLE; returns at the negedge of the first IDLE cycle after done
  task automatic run(input logic [7:0] b, input logic [7:0] n, input logic [7:0] d,
                     input logic [15:0] exp_sum, input logic exp_ovf, input bit hold);
    int nn;
    logic exp_rd, exp_wr;
    logic [7:0] exp_addr, off;
    logic [15:0] exp_wd;
    nn = int'(n);
    base_addr = b; count = n; dest_addr = d; start = 1'b1;
    @(negedge clock);
    if (!hold) start = 1'b0;
    for (int c = 1; c <= 2*nn+2; c++) begin
      exp_rd = (c <= 2*nn) && (c % 2 == 1);
      exp_wr = (c == 2*nn+1);
      off    = 8'((c-1)/2);
      exp_addr = exp_rd ? 8'(b + off) : (exp_wr ? d : 8'h00);
      exp_wd   = exp_wr ? exp_sum : 16'h0000;
      check($sformatf("rd c%0d", c),    {31'd0, mem_read},  {31'd0, exp_rd});
      check($sformatf("wr c%0d", c),    {31'd0, mem_write}, {31'd0, exp_wr});
      check($sformatf("busy c%0d", c),  {31'd0, busy},      {31'd0, (c <= 2*nn+1)});
      check($sformatf("done c%0d", c),  {31'd0, done},      {31'd0, (c == 2*nn+2)});
      check($sformatf("addr c%0d", c),  {24'd0, mem_address}, {24'd0, exp_addr});
      check($sformatf("wdata c%0d", c), {16'd0, mem_wdata}, {16'd0, exp_wd});
      if (hold && c == 3) begin base_addr = 8'h80; count = 8'd7; dest_addr = 8'h90; end
      if (hold && c == 2*nn+2) begin base_addr = b; count = n; dest_addr = d; end
      @(negedge clock);
    end
    check("sum_final", {16'd0, sum}, {16'd0, exp_sum});
    check("ovf_final", {31'd0, overflow}, {31'd0, exp_ovf});
    check("done_clear", {31'd0, done}, 32'd0);
  endtask

  initial begin
    bit got_done;
    reset_n = 1'b0; start = 1'b0; pl_en = 1'b0; pl_addr = 8'h00; pl_data = 16'h0000;
    base_addr = 8'h00; count = 8'h00; dest_addr = 8'h00;
    repeat (3) @(negedge clock);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", {16'd0, sum}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_rd", {31'd0, mem_read}, 32'd0);
    check("rst_wr", {31'd0, mem_write}, 32'd0);
    check("rst_addr", {24'd0, mem_address}, 32'd0);
    reset_n = 1'b1;

    // Test 1: basic sum of 1..4
    preload(8'd10, 16'h0001); preload(8'd11, 16'h0002);
    preload(8'd12, 16'h0003); preload(8'd13, 16'h0004);
    preload(8'd20, 16'hBEEF);
    run(8'd10, 8'd4, 8'd20, 16'h000A, 1'b0, 1'b0);
    check("t1_mem20", {16'd0, mem[20]}, 32'h0000_000A);

    // Test 2: count zero writes zero
    preload(8'd30, 16'h1234);
    run(8'd5, 8'd0, 8'd30, 16'h0000, 1'b0, 1'b0);
    check("t2_mem30", {16'd0, mem[30]}, 32'd0);

    // Test 3: carry-out sets overflow
    preload(8'd40, 16'hFFFF); preload(8'd41, 16'h0002); preload(8'd50, 16'h5555);
    run(8'd40, 8'd2, 8'd50, 16'h0001, 1'b1, 1'b0);
    check("t3_mem50", {16'd0, mem[50]}, 32'h0000_0001);

    // Test 4: address wrap FE, FF, 00; overflow cleared by new start
    preload(8'hFE, 16'h0001); preload(8'hFF, 16'h0001); preload(8'h00, 16'h0001);
    run(8'hFE, 8'd3, 8'd60, 16'h0003, 1'b0, 1'b0);
    check("t4_mem60", {16'd0, mem[60]}, 32'h0000_0003);

    // Test 5: reset during the second ACC aborts without write
    preload(8'd20, 16'hBEEF);
    base_addr = 8'd10; count = 8'd4; dest_addr = 8'd20; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    check("t5_in_acc", {31'd0, mem_read}, 32'd0);
    check("t5_sum_mid", {16'd0, sum}, 32'h0000_0001);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_sum", {16'd0, sum}, 32'd0);
    check("t5_rd", {31'd0, mem_read}, 32'd0);
    check("t5_wr", {31'd0, mem_write}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      check("t5_no_done", {31'd0, done}, 32'd0);
      check("t5_no_wr", {31'd0, mem_write}, 32'd0);
      @(negedge clock);
    end
    check("t5_mem20", {16'd0, mem[20]}, 32'h0000_BEEF);

    // Test 6: start held high, inputs disturbed mid-run
    run(8'd10, 8'd4, 8'd20, 16'h000A, 1'b0, 1'b1);
    check("t6_mem20", {16'd0, mem[20]}, 32'h0000_000A);
    check("t6_idle_busy", {31'd0, busy}, 32'd0);
    check("t6_idle_rd", {31'd0, mem_read}, 32'd0);
    @(negedge clock);
    start = 1'b0;
    check("t6_rerun_rd", {31'd0, mem_read}, 32'd1);
    check("t6_rerun_addr", {24'd0, mem_address}, 32'd10);
    check("t6_rerun_sum", {16'd0, sum}, 32'd0);
    got_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check("t6_rerun_done", {31'd0, got_done}, 32'd1);
    check("t6_rerun_sum_end", {16'd0, sum}, 32'h0000_000A);
    check("t6_rerun_mem20", {16'd0, mem[20]}, 32'h0000_000A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
